// File: rtl/cacc_dlv_pkg.sv
// Shared sizing for the CACC delivery drain and the field layout of its SDP beat.
// Field offsets locate {layer_end, stripe_end, last_beat, data} within sdp_pd.
package cacc_dlv_pkg;
  localparam int DLV_WIDTH     = 256;
  localparam int SLICE_WIDTH   = 64;
  localparam int DEPTH         = 4;
  localparam int BEATS         = DLV_WIDTH / SLICE_WIDTH;
  localparam int PD_DATA_LSB   = 0;
  localparam int PD_LAST_BIT   = SLICE_WIDTH;
  localparam int PD_STRIPE_BIT = SLICE_WIDTH + 1;
  localparam int PD_LAYER_BIT  = SLICE_WIDTH + 2;
  localparam int PD_WIDTH      = SLICE_WIDTH + 3;
endpackage

// File: rtl/cacc_dlv_ram.sv
// Entry storage: one write port, one asynchronous read port, contents never reset.
// Latency: write visible on the read port the cycle after the write; no backpressure.
module cacc_dlv_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 258
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/cacc_dlv_drain.sv
// Buffers unstallable accumulator entries and drains each as BEATS slices, returning one credit per pop.
// Latency: entry presentable one cycle after write; sdp_prdy stalls hold sdp_pd; full-without-pop writes drop and set ovf_err.
module cacc_dlv_drain
  import cacc_dlv_pkg::*;
#(
  parameter int DLV_WIDTH   = cacc_dlv_pkg::DLV_WIDTH,
  parameter int SLICE_WIDTH = cacc_dlv_pkg::SLICE_WIDTH,
  parameter int DEPTH       = cacc_dlv_pkg::DEPTH
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rst,
  input  logic                   dlv_valid,
  input  logic                   dlv_mask,
  input  logic [DLV_WIDTH-1:0]   dlv_data,
  input  logic [1:0]             dlv_pd,
  output logic                   dlv_credit,
  output logic                   sdp_pvld,
  input  logic                   sdp_prdy,
  output logic [SLICE_WIDTH+2:0] sdp_pd,
  output logic                   layer_done,
  output logic                   ovf_err
);
  localparam int NBEATS = DLV_WIDTH / SLICE_WIDTH;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int ENT_W  = DLV_WIDTH + 2;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              credit_q, credit_d;
  logic              layer_done_q, layer_done_d;
  logic              ovf_q, ovf_d;

  logic [ENT_W-1:0]                    rd_entry;
  logic [NBEATS-1:0][SLICE_WIDTH-1:0]  rd_slices;
  logic wr_req, full, accept, last_beat, pop, wr_en;

  cacc_dlv_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_ram (
    .clk_i   (nvdla_core_clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i ({dlv_pd, dlv_data}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  assign rd_slices = rd_entry[DLV_WIDTH-1:0];
  assign wr_req    = dlv_valid & dlv_mask;
  assign sdp_pvld  = (count_q != '0);
  assign last_beat = (beat_q == BEAT_W'(NBEATS - 1));
  assign accept    = sdp_pvld & sdp_prdy;
  assign pop       = accept & last_beat;
  assign full      = (count_q == CNT_W'(DEPTH));
  // A full FIFO still takes the write when the head entry leaves in the same cycle.
  assign wr_en     = wr_req & (~full | pop);

  assign sdp_pd = {rd_entry[DLV_WIDTH+1] & last_beat,
                   rd_entry[DLV_WIDTH]   & last_beat,
                   last_beat,
                   rd_slices[beat_q]};

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    beat_d       = beat_q;
    credit_d     = pop;
    layer_done_d = pop & rd_entry[DLV_WIDTH+1];
    ovf_d        = ovf_q | (wr_req & full & ~pop);

    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (accept) beat_d = last_beat ? '0 : beat_q + BEAT_W'(1);

    if (wr_en && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !wr_en) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      beat_q       <= '0;
      credit_q     <= 1'b0;
      layer_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      beat_q       <= beat_d;
      credit_q     <= credit_d;
      layer_done_q <= layer_done_d;
      ovf_q        <= ovf_d;
    end
  end

  assign dlv_credit = credit_q;
  assign layer_done = layer_done_q;
  assign ovf_err    = ovf_q;
endmodule

// File: tb/tb_cacc_dlv_drain.sv
// Directed bench for cacc_dlv_drain: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_cacc_dlv_drain;
  import cacc_dlv_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 dlv_valid, dlv_mask;
  logic [DLV_WIDTH-1:0] dlv_data;
  logic [1:0]           dlv_pd;
  logic                 dlv_credit, sdp_pvld, sdp_prdy, layer_done, ovf_err;
  logic [PD_WIDTH-1:0]  sdp_pd;

  cacc_dlv_drain #(
    .DLV_WIDTH   (DLV_WIDTH),
    .SLICE_WIDTH (SLICE_WIDTH),
    .DEPTH       (DEPTH)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .dlv_valid      (dlv_valid),
    .dlv_mask       (dlv_mask),
    .dlv_data       (dlv_data),
    .dlv_pd         (dlv_pd),
    .dlv_credit     (dlv_credit),
    .sdp_pvld       (sdp_pvld),
    .sdp_prdy       (sdp_prdy),
    .sdp_pd         (sdp_pd),
    .layer_done     (layer_done),
    .ovf_err        (ovf_err)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] W0 = 64'h0123_4567_89ab_cdef;
  localparam logic [63:0] W1 = 64'hfedc_ba98_7654_3210;
  localparam logic [63:0] W2 = 64'h0f1e_2d3c_4b5a_6978;
  localparam logic [63:0] W3 = 64'h8796_a5b4_c3d2_e1f0;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int credit_cnt = 0, ld_cnt = 0, beat_cnt = 0;
  int credit_cyc = -1, ld_cyc = -1, t_wr = 0;
  logic [PD_WIDTH-1:0] exp_q[$];
  logic [PD_WIDTH-1:0] exp_e, prev_pd;
  bit prev_stall = 0;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard compare on every accepted beat, stall stability, pulse logging.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && sdp_pvld) check("stall_hold", 128'(sdp_pd), 128'(prev_pd));
      if (sdp_pvld && sdp_prdy) begin
        beat_cnt++;
        check("sb_nonempty", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          check("beat_pd", 128'(sdp_pd), 128'(exp_e));
        end
      end
      prev_stall = sdp_pvld & ~sdp_prdy;
      prev_pd    = sdp_pd;
    end
    if (dlv_credit) begin credit_cnt++; credit_cyc = cyc; end
    if (layer_done) begin ld_cnt++; ld_cyc = cyc; end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DLV_WIDTH-1:0] mkd(input int k);
    logic [DLV_WIDTH-1:0] d;
    d = '0;
    for (int b = 0; b < BEATS; b++)
      d[b*SLICE_WIDTH +: SLICE_WIDTH] = 64'hC0DE_0000_0000_0000 | 64'(k * 16 + b);
    return d;
  endfunction

  task automatic push_entry(input logic [DLV_WIDTH-1:0] d, input logic [1:0] pd, input int nb);
    logic [PD_WIDTH-1:0] e;
    for (int b = 0; b < nb; b++) begin
      e = '0;
      e[SLICE_WIDTH-1:0] = d[b*SLICE_WIDTH +: SLICE_WIDTH];
      if (b == BEATS - 1) begin
        e[PD_LAST_BIT]   = 1'b1;
        e[PD_STRIPE_BIT] = pd[0];
        e[PD_LAYER_BIT]  = pd[1];
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_wr(input logic [DLV_WIDTH-1:0] d, input logic [1:0] pd, input logic m);
    dlv_valid = 1'b1;
    dlv_mask  = m;
    dlv_data  = d;
    dlv_pd    = pd;
    t_wr      = cyc;
    tick();
    dlv_valid = 1'b0;
    dlv_mask  = 1'b0;
  endtask

  task automatic drain(input bit patterned, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      sdp_prdy = patterned ? pat[i % 4] : 1'b1;
      tick();
    end
    sdp_prdy = 1'b0;
    check("drain_done", 128'(done), 128'(1));
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int b_cr, b_ld, b_bt;

  initial begin
    // Reset with a masked write held on the inputs: it must be ignored.
    rst = 1'b1; dlv_valid = 1'b1; dlv_mask = 1'b1; dlv_data = mkd(0); dlv_pd = 2'b11; sdp_prdy = 1'b0;
    repeat (3) tick();
    rst = 1'b0; dlv_valid = 1'b0; dlv_mask = 1'b0;
    check("rst_pvld", 128'(sdp_pvld), 128'(0));
    check("rst_credit", 128'(dlv_credit), 128'(0));
    check("rst_layer_done", 128'(layer_done), 128'(0));
    check("rst_ovf", 128'(ovf_err), 128'(0));
    tick();
    check("rst_write_ignored", 128'(sdp_pvld), 128'(0));

    // Single entry, full layer end, prdy held high.
    exp_q.push_back({3'b000, W0});
    exp_q.push_back({3'b000, W1});
    exp_q.push_back({3'b000, W2});
    exp_q.push_back({3'b111, W3});
    sdp_prdy = 1'b1;
    dlv_valid = 1'b1; dlv_mask = 1'b1; dlv_data = {W3, W2, W1, W0}; dlv_pd = 2'b11; t_wr = cyc;
    @(negedge clk);
    check("no_comb_path", 128'(sdp_pvld), 128'(0));
    tick();
    dlv_valid = 1'b0; dlv_mask = 1'b0;
    @(negedge clk);
    check("first_beat_t1", 128'(sdp_pvld), 128'(1));
    repeat (8) tick();
    sdp_prdy = 1'b0;
    check("t1_credit_cyc", 128'(credit_cyc), 128'(t_wr + 5));
    check("t1_layer_done_cyc", 128'(ld_cyc), 128'(t_wr + 5));
    check("t1_credit_cnt", 128'(credit_cnt), 128'(1));
    check("t1_sb_empty", 128'(exp_q.size()), 128'(0));

    // Two entries drained with prdy pattern 1,0,0,1.
    b_cr = credit_cnt; b_ld = ld_cnt; b_bt = beat_cnt;
    push_entry(mkd(1), 2'b01, BEATS); drive_wr(mkd(1), 2'b01, 1'b1);
    push_entry(mkd(2), 2'b00, BEATS); drive_wr(mkd(2), 2'b00, 1'b1);
    drain(1'b1, 200);
    check("t2_beats", 128'(beat_cnt - b_bt), 128'(8));
    check("t2_credits", 128'(credit_cnt - b_cr), 128'(2));
    check("t2_layer_done", 128'(ld_cnt - b_ld), 128'(0));

    // Fill to DEPTH with prdy low, then an overflowing fifth write.
    b_cr = credit_cnt; b_ld = ld_cnt; b_bt = beat_cnt;
    for (int k = 0; k < 4; k++) begin
      push_entry(mkd(10 + k), (k == 3) ? 2'b10 : 2'b00, BEATS);
      drive_wr(mkd(10 + k), (k == 3) ? 2'b10 : 2'b00, 1'b1);
    end
    check("t3_full_no_ovf", 128'(ovf_err), 128'(0));
    check("t3_full_pvld", 128'(sdp_pvld), 128'(1));
    drive_wr(mkd(99), 2'b11, 1'b1);
    check("t3_ovf_set", 128'(ovf_err), 128'(1));
    tick();
    check("t3_no_credit_on_drop", 128'(credit_cnt - b_cr), 128'(0));
    drain(1'b0, 200);
    check("t3_beats", 128'(beat_cnt - b_bt), 128'(16));
    check("t3_credits", 128'(credit_cnt - b_cr), 128'(4));
    check("t3_layer_done", 128'(ld_cnt - b_ld), 128'(1));
    check("t3_ovf_sticky", 128'(ovf_err), 128'(1));
    do_reset();
    check("t3_ovf_cleared", 128'(ovf_err), 128'(0));

    // Full FIFO, fifth write lands in the same cycle as the head's last beat.
    b_cr = credit_cnt; b_ld = ld_cnt; b_bt = beat_cnt;
    for (int k = 0; k < 4; k++) begin
      push_entry(mkd(20 + k), 2'b00, BEATS);
      drive_wr(mkd(20 + k), 2'b00, 1'b1);
    end
    sdp_prdy = 1'b1;
    tick(); tick(); tick();
    push_entry(mkd(25), 2'b11, BEATS);
    drive_wr(mkd(25), 2'b11, 1'b1);
    check("t4_no_ovf", 128'(ovf_err), 128'(0));
    drain(1'b0, 200);
    check("t4_beats", 128'(beat_cnt - b_bt), 128'(20));
    check("t4_credits", 128'(credit_cnt - b_cr), 128'(5));
    check("t4_layer_done", 128'(ld_cnt - b_ld), 128'(1));

    // Unmasked strobe: no write, no beat, no credit.
    b_cr = credit_cnt;
    drive_wr(mkd(30), 2'b11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t5_pvld_low", 128'(sdp_pvld), 128'(0));
      tick();
    end
    check("t5_no_credit", 128'(credit_cnt - b_cr), 128'(0));

    // Reset after 2 of 4 beats with 2 entries queued.
    b_cr = credit_cnt; b_ld = ld_cnt;
    push_entry(mkd(40), 2'b11, 2);
    drive_wr(mkd(40), 2'b11, 1'b1);
    drive_wr(mkd(41), 2'b11, 1'b1);
    sdp_prdy = 1'b1;
    tick(); tick();
    rst = 1'b1; sdp_prdy = 1'b0;
    tick();
    rst = 1'b0;
    check("t6_pvld_after_rst", 128'(sdp_pvld), 128'(0));
    tick(); tick(); tick();
    check("t6_no_credit", 128'(credit_cnt - b_cr), 128'(0));
    check("t6_no_layer_done", 128'(ld_cnt - b_ld), 128'(0));
    check("t6_sb_empty", 128'(exp_q.size()), 128'(0));
    push_entry(mkd(42), 2'b01, BEATS);
    drive_wr(mkd(42), 2'b01, 1'b1);
    drain(1'b0, 200);
    check("t6_fresh_credit", 128'(credit_cnt - b_cr), 128'(1));

    check("final_sb_empty", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
